msk_rnd_source: RTL
===================

Name: msk_rnd_source

Overview:
- Fresh-randomness producer that feeds the rnd_ref/rnd_mul style random inputs of masked gadgets (refresh, DOM AND, HPC1 AND).
- Holds a 128-bit xorshift128 PRNG, seeded over a word-serial handshake.
- Delivers NRND-bit random words on a valid/ready interface.
- Sits between the top-level seed/TRNG path and the masked datapath.

Parameters:
- d, 2: share count of the consuming gadgets; documentation and assertions only, no datapath effect.
- NRND, 32: output randomness width in bits; 1..256.
- K, derived ceil(NRND/32): PRNG steps per output word; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- seed_in  in  32  seed word.
- seed_valid  in  1  seed word offered.
- seed_ready  out  1  high in SEED state.
- reseed  in  1  single-cycle request to return to SEED.
- rnd_out  out  NRND  random word.
- rnd_valid  out  1  rnd_out holds an unconsumed word.
- rnd_ready  in  1  consumer accepts.
- alarm  out  1  health-test failure flag, sticky.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=SEED, seed_cnt=0, fill_cnt=0.
  - rnd_valid=0, rnd_out=0, alarm=0, seed_ready=1.
  - PRNG state x,y,z,w = 0.
- SEED state:
  - Each cycle with seed_valid & seed_ready, load seed_in into x, y, z, w in that order; seed_cnt increments 0..3.
  - On the 4th accept (cycle T), go to RUN at T+1.
  - If all four words are zero, force w=1 when the 4th word is accepted.
- RUN state, PRNG step (single combinational cycle):
  - t = x ^ (x<<11)
  - x'=y; y'=z; z'=w
  - w' = w ^ (w>>19) ^ t ^ (t>>8)
  - Emitted word = w'.
- Fill buffer:
  - The k-th step of a fill (k=0..K-1) writes bits [32k+31:32k], clipped to NRND; the first word lands in the LSBs.
  - Upper bits of the last word beyond NRND are discarded.
- Transfer to output:
  - When fill_cnt reaches K, the buffer moves to rnd_out and rnd_valid=1 on the next edge, if rnd_valid=0 or rnd_ready=1 that cycle.
  - fill_cnt resets and filling continues.
- Stall: if the buffer is full and the output is held (rnd_valid & ~rnd_ready), the PRNG does not step and state is frozen.
- Throughput:
  - One word per K cycles sustained; for K=1, one word per cycle.
  - Latency from the 4th seed accept at T to the first rnd_valid: T+K+1.
- rnd_out is stable while rnd_valid & ~rnd_ready (AXI-style hold rule).
- reseed in RUN:
  - Next state is SEED; rnd_valid=0, fill_cnt=0, seed_cnt=0.
  - If rnd_valid & rnd_ready in the same cycle, that word counts as delivered.
  - The PRNG state is overwritten by the new seed words.
- reseed while already in SEED: restarts seeding (seed_cnt=0). A seed word accepted in the same cycle is discarded.
- seed_valid in RUN is ignored; seed_ready=0.
- rst_n has priority over everything, mid-fill or mid-seed.

Optional Feature:
- Macro MSKRND_HEALTH_EN.
- Defined: repetition test. If an output word is transferred into rnd_out equal to the previous transferred word, alarm is set on the next cycle. alarm stays set until reset or reseed.
- Not defined: alarm tied to 0; no comparison register is synthesised.

Decomposition:
- Package msk_rnd_pkg:
  - state enum {SEED, RUN}.
  - WORD_W=32, SEED_WORDS=4.
  - Shift constants 11/19/8.
  - Function nwords(NRND) returning K.
- Sub-module msk_xorshift128_step: combinational next state plus output word, instantiated once.

Test Plan:
- Seed 123456789, 362436069, 521288629, 88675123 with NRND=32 and rnd_ready=1 → first three words 3701687786, 458299110, 2500872618 on consecutive cycles; first rnd_valid at T+2.
- Same seed with NRND=64 → first rnd_out = {458299110, 3701687786} (upper, lower); valid at T+3; a new word every 2 cycles.
- All-zero seed → w forced to 1; rnd_out nonzero; alarm stays 0 over 1000 words.
- rnd_ready=0 for 10 cycles after first valid → rnd_out unchanged; on release, the next word equals the uninterrupted sequence's second word (458299110).
- reseed pulse in the same cycle as a handshake → that word counted; rnd_valid=0 next cycle; seed_ready=1; reseeding with the same seed restarts the sequence at 3701687786.
- With MSKRND_HEALTH_EN, force the step output constant via testbench override → alarm=1 one cycle after the second equal transfer; cleared by reseed.

Source files
------------

// File: rtl/msk_rnd_pkg.sv
// Shared types and constants for the masked-gadget randomness source.
package msk_rnd_pkg;

  typedef enum logic {SEED = 1'b0, RUN = 1'b1} state_t;

  localparam int WORD_W     = 32;
  localparam int SEED_WORDS = 4;
  localparam int SH_A       = 11;
  localparam int SH_B       = 19;
  localparam int SH_C       = 8;

  // Number of 32-bit PRNG steps needed to fill one output word.
  function automatic int nwords(input int n);
    return (n + WORD_W - 1) / WORD_W;
  endfunction

endpackage

// File: rtl/msk_xorshift128_step.sv
// One combinational xorshift128 step: next state and the emitted word (the new w).
module msk_xorshift128_step
  import msk_rnd_pkg::*;
(
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [31:0] z,
  input  logic [31:0] w,
  output logic [31:0] x_nxt,
  output logic [31:0] y_nxt,
  output logic [31:0] z_nxt,
  output logic [31:0] w_nxt
);

  logic [31:0] t;

  assign t     = x ^ (x << SH_A);
  assign x_nxt = y;
  assign y_nxt = z;
  assign z_nxt = w;
  assign w_nxt = w ^ (w >> SH_B) ^ t ^ (t >> SH_C);

endmodule

// File: rtl/msk_rnd_source.sv
// Word-serially seeded xorshift128 randomness source with a valid/ready output of NRND bits.
// Optional repetition health test enabled by defining MSKRND_HEALTH_EN.
module msk_rnd_source
  import msk_rnd_pkg::*;
#(
  parameter int d    = 2,
  parameter int NRND = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     seed_in,
  input  logic            seed_valid,
  output logic            seed_ready,
  input  logic            reseed,
  output logic [NRND-1:0] rnd_out,
  output logic            rnd_valid,
  input  logic            rnd_ready,
  output logic            alarm
);

  localparam int K  = nwords(NRND);
  localparam int BW = K * WORD_W;
  localparam int FW = $clog2(K + 1);

  state_t          state, state_nxt;
  logic [1:0]      seed_cnt;
  logic [FW-1:0]   fill_cnt, widx;
  logic [BW-1:0]   fill_buf, fill_buf_nxt;
  logic [31:0]     x, y, z, w;
  logic [31:0]     x_n, y_n, z_n, step_w;
  logic            seed_acc, full, can_out, step_en, last_word, xfer;
  logic [NRND-1:0] xfer_word;

  msk_xorshift128_step u_step (
    .x(x), .y(y), .z(z), .w(w),
    .x_nxt(x_n), .y_nxt(y_n), .z_nxt(z_n), .w_nxt(step_w)
  );

  assign seed_acc  = (state == SEED) & seed_valid & ~reseed;
  assign full      = (fill_cnt == FW'(K));
  assign can_out   = ~rnd_valid | rnd_ready;
  // A completed fill that cannot leave freezes the PRNG until the consumer takes rnd_out.
  assign step_en   = (state == RUN) & ~reseed & ~(full & ~can_out);
  assign last_word = ~full & (fill_cnt == FW'(K - 1));
  assign xfer      = step_en & can_out & (full | last_word);
  assign widx      = full ? '0 : fill_cnt;
  assign xfer_word = full ? fill_buf[NRND-1:0] : fill_buf_nxt[NRND-1:0];

  always_comb begin
    fill_buf_nxt = fill_buf;
    for (int k = 0; k < K; k++) begin
      if (widx == FW'(k)) fill_buf_nxt[k*WORD_W +: WORD_W] = step_w;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= SEED;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SEED: if (seed_acc && seed_cnt == 2'(SEED_WORDS - 1)) state_nxt = RUN;
      RUN:  if (reseed) state_nxt = SEED;
      default: state_nxt = SEED;
    endcase
  end

  always_comb begin
    seed_ready = (state == SEED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seed_cnt <= '0;
      x <= '0; y <= '0; z <= '0; w <= '0;
    end else begin
      if (reseed)        seed_cnt <= '0;
      else if (seed_acc) seed_cnt <= seed_cnt + 2'd1;
      if (seed_acc) begin
        case (seed_cnt)
          2'd0: x <= seed_in;
          2'd1: y <= seed_in;
          2'd2: z <= seed_in;
          default: w <= ((x | y | z | seed_in) == '0) ? 32'd1 : seed_in;
        endcase
      end else if (step_en) begin
        x <= x_n; y <= y_n; z <= z_n; w <= step_w;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_cnt  <= '0;
      fill_buf  <= '0;
      rnd_out   <= '0;
      rnd_valid <= 1'b0;
    end else if (reseed) begin
      fill_cnt  <= '0;
      rnd_valid <= 1'b0;
    end else begin
      if (step_en) begin
        fill_buf <= fill_buf_nxt;
        if (full)           fill_cnt <= FW'(1);
        else if (last_word) fill_cnt <= xfer ? '0 : FW'(K);
        else                fill_cnt <= fill_cnt + FW'(1);
      end
      if (xfer) begin
        rnd_out   <= xfer_word;
        rnd_valid <= 1'b1;
      end else if (rnd_ready) begin
        rnd_valid <= 1'b0;
      end
    end
  end

`ifdef MSKRND_HEALTH_EN
  logic [NRND-1:0] prev_word;
  logic            have_prev, chk_pend;

  // Compare one cycle after each transfer: rnd_out then holds the new word, prev_word the old one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_word <= '0;
      have_prev <= 1'b0;
      chk_pend  <= 1'b0;
      alarm     <= 1'b0;
    end else if (reseed) begin
      have_prev <= 1'b0;
      chk_pend  <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      chk_pend <= 1'b0;
      if (xfer) begin
        prev_word <= rnd_out;
        have_prev <= 1'b1;
        chk_pend  <= have_prev;
      end
      if (chk_pend && rnd_out == prev_word) alarm <= 1'b1;
    end
  end
`else
  assign alarm = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst_n) assert (d >= 2 && NRND >= 1 && NRND <= 256);
  end

endmodule
